// File: rtl/param_sync_counter.sv
// param_sync_counter: parametrised up/down counter with load, clear, wrap/saturate and cascade carry
module param_sync_counter #(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter int              SATURATE  = 0,
    parameter int              RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             wrapped
);
    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam bit               SAT     = SATURATE != 0;
    logic             at_term;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamp;
    // terminal detect for the current direction, next counting value and clamped load value
    always_comb begin
        at_term    = up_dn ? count == MAX : count == '0;
        step_val   = at_term ? (SAT ? count : (up_dn ? '0 : MAX))
                             : (up_dn ? count + WIDTH'(1) : count - WIDTH'(1));
        load_clamp = load_val > MAX ? MAX : load_val;
    end
    assign carry = cnt_en & ~rst & ~clear & ~load & at_term;
    // priority rst > clear > load > cnt_en; wrapped pulses on the edge that wraps count
    always_ff @(posedge clk) begin
        if (rst)
            count <= RST_VAL;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_clamp;
        else if (cnt_en)
            count <= step_val;
        wrapped <= !SAT && carry;
    end
endmodule

// File: tb/tb_param_sync_counter.sv
// tb_param_sync_counter: randomized and directed checks of param_sync_counter against an arithmetic model
module tb_param_sync_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, ud = 1'b1, clr = 1'b0, ld = 1'b0;
    logic [3:0] lv = '0;
    logic [3:0] w_count, s_count, lo_count, hi_count;
    logic [2:0] r_count;
    logic w_carry, s_carry, r_carry, w_wrap, s_wrap, r_wrap;
    logic c_rst = 1'b1, c_en = 1'b0;
    logic lo_carry, hi_carry, lo_wrap, hi_wrap;
    int total = 0, bad = 0;
    int mw = 0, ms = 0, mr = 0;
    bit xw = 0;

    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_w (
        .clk(clk), .rst(rst), .cnt_en(en), .up_dn(ud), .clear(clr), .load(ld), .load_val(lv),
        .count(w_count), .carry(w_carry), .wrapped(w_wrap));
    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0)) u_s (
        .clk(clk), .rst(rst), .cnt_en(en), .up_dn(ud), .clear(clr), .load(ld), .load_val(lv),
        .count(s_count), .carry(s_carry), .wrapped(s_wrap));
    param_sync_counter #(.WIDTH(3), .MODULUS(5), .SATURATE(1), .RESET_VAL(2)) u_r (
        .clk(clk), .rst(rst), .cnt_en(en), .up_dn(ud), .clear(clr), .load(ld), .load_val(lv[2:0]),
        .count(r_count), .carry(r_carry), .wrapped(r_wrap));
    param_sync_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_lo (
        .clk(clk), .rst(c_rst), .cnt_en(c_en), .up_dn(1'b1), .clear(1'b0), .load(1'b0), .load_val(4'd0),
        .count(lo_count), .carry(lo_carry), .wrapped(lo_wrap));
    param_sync_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_hi (
        .clk(clk), .rst(c_rst), .cnt_en(lo_carry), .up_dn(1'b1), .clear(1'b0), .load(1'b0), .load_val(4'd0),
        .count(hi_count), .carry(hi_carry), .wrapped(hi_wrap));

    function automatic int nxt(int c, int m, bit sat, int rv, int v);
        if (rst) return rv;
        if (clr) return 0;
        if (ld) return v < m ? v : m - 1;
        if (!en) return c;
        if (ud) return sat ? (c + 1 < m ? c + 1 : c) : (c + 1) % m;
        return sat ? (c > 0 ? c - 1 : 0) : (c + m - 1) % m;
    endfunction

    function automatic bit cry(int c, int m);
        return en && !rst && !clr && !ld && (ud ? c == m - 1 : c == 0);
    endfunction

    task automatic set_in(bit r, bit e, bit u, bit c, bit l, logic [3:0] v);
        rst = r; en = e; ud = u; clr = c; ld = l; lv = v;
        #1;
    endtask

    task automatic step;
        int nw, ns, nr;
        bit x;
        nw = nxt(mw, 10, 0, 0, int'(lv));
        ns = nxt(ms, 10, 1, 0, int'(lv));
        nr = nxt(mr, 5, 1, 2, int'(lv[2:0]));
        x = cry(mw, 10);
        @(posedge clk);
        #1;
        mw = nw; ms = ns; mr = nr; xw = x;
    endtask

    task automatic test_reset;
        set_in(1, 1, 1, 1, 1, 4'd7);
        total++; if (w_carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", w_carry); end
        step; step;
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL reset_w_count got=%0d exp=0", w_count); end
        total++; if (w_wrap !== 1'b0) begin bad++; $display("FAIL reset_w_wrap got=%b exp=0", w_wrap); end
        total++; if (s_count !== 4'd0) begin bad++; $display("FAIL reset_s_count got=%0d exp=0", s_count); end
        total++; if (r_count !== 3'd2) begin bad++; $display("FAIL reset_r_count got=%0d exp=2", r_count); end
    endtask

    task automatic test_up_wrap;
        int pulses = 0;
        set_in(1, 0, 1, 0, 0, 0); step;
        set_in(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            total++; if (w_carry !== (i % 10 == 9)) begin bad++; $display("FAIL up_carry i=%0d got=%b exp=%b", i, w_carry, i % 10 == 9); end
            step;
            total++; if (w_count !== 4'((i + 1) % 10)) begin bad++; $display("FAIL up_count i=%0d got=%0d exp=%0d", i, w_count, (i + 1) % 10); end
            total++; if (w_wrap !== ((i + 1) % 10 == 0)) begin bad++; $display("FAIL up_wrap i=%0d got=%b exp=%b", i, w_wrap, (i + 1) % 10 == 0); end
            pulses += int'(w_wrap);
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL up_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_down_wrap;
        set_in(1, 0, 0, 0, 0, 0); step;
        set_in(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            int b = (10 - i % 10) % 10;
            int a = (10 - (i + 1) % 10) % 10;
            total++; if (w_carry !== (b == 0)) begin bad++; $display("FAIL dn_carry i=%0d got=%b exp=%b", i, w_carry, b == 0); end
            step;
            total++; if (w_count !== 4'(a)) begin bad++; $display("FAIL dn_count i=%0d got=%0d exp=%0d", i, w_count, a); end
            total++; if (w_wrap !== (b == 0)) begin bad++; $display("FAIL dn_wrap i=%0d got=%b exp=%b", i, w_wrap, b == 0); end
        end
    endtask

    task automatic test_saturate;
        set_in(1, 0, 1, 0, 0, 0); step;
        set_in(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            int b = i < 9 ? i : 9;
            total++; if (s_carry !== (b == 9)) begin bad++; $display("FAIL sat_up_carry i=%0d got=%b exp=%b", i, s_carry, b == 9); end
            step;
            total++; if (s_count !== 4'(i + 1 < 9 ? i + 1 : 9)) begin bad++; $display("FAIL sat_up_count i=%0d got=%0d", i, s_count); end
            total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_up_wrap i=%0d got=%b exp=0", i, s_wrap); end
        end
        set_in(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            int b = 9 - i > 0 ? 9 - i : 0;
            total++; if (s_carry !== (b == 0)) begin bad++; $display("FAIL sat_dn_carry i=%0d got=%b exp=%b", i, s_carry, b == 0); end
            step;
            total++; if (s_count !== 4'(8 - i > 0 ? 8 - i : 0)) begin bad++; $display("FAIL sat_dn_count i=%0d got=%0d", i, s_count); end
            total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_dn_wrap i=%0d got=%b exp=0", i, s_wrap); end
        end
    endtask

    task automatic test_load;
        set_in(0, 0, 1, 0, 1, 4'd9); step;
        set_in(0, 1, 1, 0, 1, 4'd7);
        total++; if (w_carry !== 1'b0) begin bad++; $display("FAIL load_carry got=%b exp=0", w_carry); end
        step;
        total++; if (w_count !== 4'd7) begin bad++; $display("FAIL load_count got=%0d exp=7", w_count); end
        total++; if (w_wrap !== 1'b0) begin bad++; $display("FAIL load_wrap got=%b exp=0", w_wrap); end
        set_in(0, 1, 1, 0, 1, 4'd13); step;
        total++; if (w_count !== 4'd9) begin bad++; $display("FAIL load_clamp_w got=%0d exp=9", w_count); end
        total++; if (s_count !== 4'd9) begin bad++; $display("FAIL load_clamp_s got=%0d exp=9", s_count); end
        total++; if (r_count !== 3'd4) begin bad++; $display("FAIL load_clamp_r got=%0d exp=4", r_count); end
    endtask

    task automatic test_priority;
        set_in(0, 0, 1, 0, 1, 4'd5); step;
        set_in(1, 1, 1, 1, 1, 4'd7); step;
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL prio_all_w got=%0d exp=0", w_count); end
        total++; if (r_count !== 3'd2) begin bad++; $display("FAIL prio_all_r got=%0d exp=2", r_count); end
        set_in(0, 0, 1, 0, 1, 4'd5); step;
        set_in(0, 1, 1, 1, 0, 4'd0); step;
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL prio_clear got=%0d exp=0", w_count); end
        set_in(0, 0, 1, 0, 1, 4'd5); step;
        set_in(0, 1, 1, 1, 1, 4'd7); step;
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL prio_clr_ld got=%0d exp=0", w_count); end
        set_in(0, 0, 1, 0, 1, 4'd9); step;
        set_in(1, 1, 1, 0, 0, 4'd0);
        total++; if (w_carry !== 1'b0) begin bad++; $display("FAIL prio_rst_carry got=%b exp=0", w_carry); end
        step;
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL prio_rst_count got=%0d exp=0", w_count); end
        total++; if (w_wrap !== 1'b0) begin bad++; $display("FAIL prio_rst_wrap got=%b exp=0", w_wrap); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                   $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0, 4'($urandom_range(0, 15)));
            total++; if (w_carry !== cry(mw, 10)) begin bad++; $display("FAIL rnd_w_carry i=%0d got=%b exp=%b", i, w_carry, cry(mw, 10)); end
            total++; if (s_carry !== cry(ms, 10)) begin bad++; $display("FAIL rnd_s_carry i=%0d got=%b exp=%b", i, s_carry, cry(ms, 10)); end
            total++; if (r_carry !== cry(mr, 5)) begin bad++; $display("FAIL rnd_r_carry i=%0d got=%b exp=%b", i, r_carry, cry(mr, 5)); end
            step;
            total++; if (w_count !== 4'(mw)) begin bad++; $display("FAIL rnd_w_count i=%0d got=%0d exp=%0d", i, w_count, mw); end
            total++; if (s_count !== 4'(ms)) begin bad++; $display("FAIL rnd_s_count i=%0d got=%0d exp=%0d", i, s_count, ms); end
            total++; if (r_count !== 3'(mr)) begin bad++; $display("FAIL rnd_r_count i=%0d got=%0d exp=%0d", i, r_count, mr); end
            total++; if (w_wrap !== xw) begin bad++; $display("FAIL rnd_w_wrap i=%0d got=%b exp=%b", i, w_wrap, xw); end
            total++; if ((s_wrap | r_wrap) !== 1'b0) begin bad++; $display("FAIL rnd_sat_wrap i=%0d got=%b%b exp=00", i, s_wrap, r_wrap); end
        end
    endtask

    task automatic test_cascade;
        c_rst = 1'b1; c_en = 1'b0;
        @(posedge clk); #1;
        c_rst = 1'b0; c_en = 1'b1;
        #1;
        for (int i = 0; i < 300; i++) begin
            total++; if ({hi_count, lo_count} !== 8'(i % 256)) begin bad++; $display("FAIL casc_val i=%0d got=%0d exp=%0d", i, {hi_count, lo_count}, i % 256); end
            total++; if (hi_carry !== (i % 256 == 255)) begin bad++; $display("FAIL casc_carry i=%0d got=%b exp=%b", i, hi_carry, i % 256 == 255); end
            @(posedge clk); #2;
        end
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_wrap;
        test_saturate;
        test_load;
        test_priority;
        test_random;
        test_cascade;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_sync_counter.md
Name: param_sync_counter

Overview:
- Parametrised synchronous up/down counter; successor to the team's fixed 4-bit T-flip-flop counter.
- Adds configurable width and modulus, direction control, parallel load, synchronous clear, and wrap or saturate mode.
- Keeps a combinational cascade carry, so stages chain into wider counters with a shared clock.
- Also provides a registered wrap pulse for event logging.

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MODULUS, 16: count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0: 0 = wrap at terminal value; 1 = hold at terminal value.
- RESET_VAL, 0: value loaded on rst; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock, only clock in the block.
- rst  input  1  reset; synchronous, active-high.
- cnt_en  input  1  count enable; also the cascade input from the previous stage's carry.
- up_dn  input  1  direction; 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  registered count value.
- carry  output  1  combinational terminal-count-and-enabled; cascades to the next stage's cnt_en.
- wrapped  output  1  registered one-cycle pulse, high the cycle after a wrap occurs.

Behaviour:
- All state updates happen on the rising edge of clk. Priority per edge: rst > clear > load > cnt_en.
- rst=1: count <= RESET_VAL, wrapped <= 0. This also applies mid-count and when load or clear is asserted in the same cycle.
- Terminal value: MODULUS-1 when up_dn=1; 0 when up_dn=0.
- carry = cnt_en & ~rst & ~clear & ~load & (count == terminal), evaluated with the current up_dn.
- carry is purely combinational, with no registered delay, so a chain of stages sharing clk increments as one wide counter in the same cycle.
- clear=1 (rst=0): count <= 0, wrapped <= 0.
- load=1 (rst=0, clear=0):
  - count <= load_val when load_val < MODULUS; otherwise count <= MODULUS-1 (clamp).
  - wrapped <= 0.
- cnt_en=1, no higher-priority input:
  - Up, count < MODULUS-1: count+1.
  - Up, count == MODULUS-1: wrap mode -> count 0; saturate mode -> hold.
  - Down, count > 0: count-1.
  - Down, count == 0: wrap mode -> count MODULUS-1; saturate mode -> hold.
- cnt_en=0, no higher-priority input: count holds.
- wrapped <= 1 only on an edge where an actual wrap occurs (wrap mode, carry=1); otherwise 0.
  - Always 0 when SATURATE=1.
  - carry still asserts at terminal in saturate mode, so a cascaded upper stage continues to advance. Saturating the full chain is the integrator's responsibility.
- Direction change takes effect on the same edge; no pipeline state depends on the previous direction.
- Arithmetic is done in WIDTH bits. When MODULUS == 2**WIDTH, wrap equals natural overflow; the compare still uses MODULUS-1.
- No X propagation: count is defined from the first edge with rst=1. Before the first reset, outputs are don't-care.
- Latency: count updates one cycle after inputs are sampled. carry follows count and inputs combinationally. wrapped lags the wrap edge by zero cycles: it is registered on the same edge that wraps count.

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0; rst 2 cycles, then cnt_en=1, up_dn=1 for 12 cycles -> count 0,1..9,0,1,2; carry high only while count=9; wrapped high for exactly one cycle, coincident with count=0 after 9.
- Same config, down count from reset -> count 0,9,8..; carry high at count=0; wrapped pulses after the 0->9 transition.
- SATURATE=1, up_dn=1, 15 enabled cycles -> count stops at 9 and holds; carry stays high while enabled at 9; wrapped never asserts. Repeat with up_dn=0 -> holds at 0.
- load_val=7 with load=1 and cnt_en=1 simultaneously -> count=7 (load wins), carry=0 that cycle. load_val=13 with MODULUS=10 -> count=9.
- Priority: at count=5, assert rst, clear and load together -> count=RESET_VAL (0). Clear alone at count=5 -> 0. Reset asserted mid-wrap (count=9, cnt_en=1) -> count 0, wrapped=0.
- Cascade: two WIDTH=4, MODULUS=16 instances, lower carry to upper cnt_en, 300 enabled cycles from reset -> concatenated value equals cycle count mod 256; upper carry high only at 0xFF while enabled.
